// File: rtl/timebase_pkg.sv
// Shared encodings for the timebase scheduler.
// Command opcodes and the per-channel run state.
package timebase_pkg;

    typedef enum logic [1:0] {
        OP_STOP      = 2'b00,
        OP_START_ONE = 2'b01,
        OP_START_PER = 2'b10,
        OP_SET_PER   = 2'b11
    } cfg_op_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN_ONE = 2'd1,
        RUN_PER = 2'd2
    } ch_state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle base_tick enable.
// base_tick is registered: high the cycle after the counter hits DIV-1.
module tick_prescaler #(
    parameter int DIV = 12000
) (
    input  logic clk,
    input  logic rst_n,
    output logic base_tick
);

    localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            base_tick <= 1'b0;
        end else begin
            base_tick <= (cnt == LAST);
            cnt       <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/timebase_sched.sv
// Timebase scheduler: one shared prescaler feeding NCH tick channels.
// Commands are stalled on base_tick cycles so they never race counting.
module timebase_sched
    import timebase_pkg::*;
#(
    parameter int CLK_HZ  = 12_000_000,
    parameter int BASE_HZ = 1000,
    parameter int NCH     = 4,
    parameter int CW      = 16,
    parameter int PER_RST = 1000,
    localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [1:0]     cfg_op,
    input  logic [CW-1:0]  cfg_period,
    output logic           base_tick,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] busy
);

    localparam int DIV = CLK_HZ / BASE_HZ;

    logic    accept;
    cfg_op_e op;

    tick_prescaler #(
        .DIV(DIV)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .base_tick(base_tick)
    );

    assign cfg_ready = ~base_tick;
    assign accept    = cfg_valid & cfg_ready;
    assign op        = cfg_op_e'(cfg_op);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        ch_state_e     state;
        logic [CW-1:0] per;
        logic [CW-1:0] cnt;
        logic          tick_q;
        logic          busy_q;
        logic          sel;

        assign sel     = accept && (cfg_ch == CHW'(i));
        assign tick[i] = tick_q;
        assign busy[i] = busy_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state  <= IDLE;
                per    <= CW'(PER_RST);
                cnt    <= '0;
                tick_q <= 1'b0;
                busy_q <= 1'b0;
            end else begin
                tick_q <= 1'b0;
                if (sel) begin
                    unique case (op)
                        OP_STOP: begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                        OP_START_ONE: begin
                            state  <= RUN_ONE;
                            busy_q <= 1'b1;
                            cnt    <= per;
                        end
                        OP_START_PER: begin
                            state  <= RUN_PER;
                            busy_q <= 1'b1;
                            cnt    <= per;
                        end
                        OP_SET_PER: begin
                            per <= (cfg_period == '0) ? CW'(1) : cfg_period;
                        end
                    endcase
                end else if (base_tick && state != IDLE) begin
                    // Terminal count: strobe, then reload or retire.
                    if (cnt == CW'(1)) begin
                        tick_q <= 1'b1;
                        if (state == RUN_PER) begin
                            cnt <= per;
                        end else begin
                            cnt    <= '0;
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
            end
        end
    end

endmodule
